bus_arbiter: RTL
================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The parameters SHALL be:
- WAIT_CYC, 1, bus wait cycles per access, range 1..15
- TIMEOUT, 0, reserved, SHALL be ignored
REQ-002 The ports SHALL be, clock and reset first:
- clk  in  1  single clock; all state changes on its rising edge
- RSTN  in  1  reset, synchronous and active-low
- m0_req  in  1  CPU request
- m0_we  in  1  CPU write enable
- m0_addr  in  32  CPU address
- m0_wdata  in  32  CPU write data
- m0_ack  out  1  CPU completion pulse
- m0_rdata  out  32  CPU read data
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata  same widths and directions as m0_*  loader/debug master
- addr_bus  out  32  shared bus address
- mem_w  out  1  shared bus write strobe
- Cpu_data2bus  out  32  shared bus write data
- Cpu_data4bus  in  32  shared bus read data
- busy  out  1  transaction in progress
- gnt_id  out  1  owner of the current or last transaction
- xfer_cnt  out  16  completed-transaction counter

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, BUSY and RESP.
REQ-004 Requests SHALL be sampled only in IDLE; in IDLE with any req high, the arbiter SHALL latch the winner's id, we, addr and wdata, load the wait counter with WAIT_CYC, and go to BUSY.
REQ-005 Arbitration SHALL be round-robin: with only one req high, that master wins; with both high, the master other than last_gnt wins.
REQ-006 last_gnt SHALL update on entry to RESP.
REQ-007 In BUSY, addr_bus and Cpu_data2bus SHALL drive the latched values.
REQ-008 In BUSY, mem_w SHALL equal the latched we during the first BUSY cycle only, and SHALL be 0 otherwise.
REQ-009 In BUSY, the counter SHALL decrement each cycle; when it reaches 0, Cpu_data4bus SHALL be captured into the granted master's rdata register and the FSM SHALL go to RESP.
REQ-010 In RESP, the granted master's ack SHALL be 1 for exactly one cycle, xfer_cnt SHALL increment (wrapping 0xFFFF->0x0000), and the next state SHALL be IDLE.
REQ-011 Latency from req sampled in IDLE at cycle N to ack high SHALL be N+WAIT_CYC+1; back-to-back accesses SHALL have throughput of one per WAIT_CYC+2 cycles.
REQ-012 A master SHALL hold req, we, addr and wdata stable until ack, and SHALL drop req in the cycle after ack unless issuing a new access.
REQ-013 Dropping req during BUSY or RESP SHALL NOT abort the transaction.
REQ-014 Changes to a master's inputs during BUSY SHALL be ignored.
REQ-015 Outside BUSY, addr_bus, Cpu_data2bus and mem_w SHALL be 0.
REQ-016 busy SHALL be 1 in BUSY and RESP.
REQ-017 The ungranted master's ack SHALL stay 0.
REQ-018 The ungranted master's rdata SHALL hold its last value.
REQ-019 For writes, rdata SHALL be updated with the sampled Cpu_data4bus value, and that value is don't-care.

Reset
REQ-020 With RSTN low at a rising edge, the FSM SHALL go to IDLE.
REQ-021 With RSTN low at a rising edge, last_gnt SHALL be set to 1, so m0 wins the first tie.
REQ-022 With RSTN low at a rising edge, xfer_cnt, gnt_id, both rdata registers, both acks, mem_w, addr_bus, Cpu_data2bus and busy SHALL be set to 0.
REQ-023 Reset asserted mid-transaction SHALL abort it with no ack and no further mem_w; the next arbitration SHALL restart with m0 priority.
REQ-024 Reset SHALL be sampled only on clk edges; asynchronous RSTN assertion SHALL have no effect until the next edge.

Verification
REQ-025 The bench SHALL cover each scenario below with the stated response.
- Single read, WAIT_CYC=1: m0_req=1, m0_we=0, m0_addr=0x0000_0010, Cpu_data4bus=0xDEAD_BEEF -> addr_bus=0x10 one cycle; m0_ack pulses at N+2; m0_rdata=0xDEADBEEF; xfer_cnt=1.
- Single write, WAIT_CYC=3: m1 writes 0x1234_5678 to 0xE000_0000 -> mem_w high for exactly 1 cycle with Cpu_data2bus=0x12345678; m1_ack at N+4; m0_ack stays 0.
- Contention after reset: m0_req and m1_req high together, held continuously -> grants alternate m0, m1, m0, m1; gnt_id toggles; each ack spaced WAIT_CYC+2 cycles.
- Reset mid-BUSY: assert RSTN=0 during the second BUSY cycle of a WAIT_CYC=3 write -> no ack, busy=0, mem_w=0 next edge; a following tie goes to m0.
- Counter wrap: preload via 65536 accesses or force xfer_cnt=0xFFFF, then complete one access -> xfer_cnt=0x0000.
- Input change during BUSY: m0_addr changes 0x10->0x20 mid-BUSY -> addr_bus stays 0x10 until RESP.

Source files
------------

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter for a shared single-port bus.
// Each access runs IDLE -> BUSY (WAIT_CYC cycles) -> RESP, so one access completes every WAIT_CYC+2 cycles.
module bus_arbiter #(
    parameter int WAIT_CYC = 1,
    parameter int TIMEOUT  = 0
) (
    input  logic        clk,
    input  logic        RSTN,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
    output logic [31:0] addr_bus,
    output logic        mem_w,
    output logic [31:0] Cpu_data2bus,
    input  logic [31:0] Cpu_data4bus,
    output logic        busy,
    output logic        gnt_id,
    output logic [15:0] xfer_cnt
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYC);

    state_t      state;
    logic [3:0]  cnt;
    logic        last_gnt;
    logic        win;
    logic        win_we;
    logic [31:0] win_addr;
    logic [31:0] win_wdata;

    // TIMEOUT is reserved and has no effect on behaviour.
    if (TIMEOUT != 0) begin : g_timeout_reserved
    end

    // A tie goes to the master that did not own the last completed access.
    always_comb begin
        win = m1_req;
        if (m0_req && m1_req)
            win = ~last_gnt;
        win_we    = win ? m1_we    : m0_we;
        win_addr  = win ? m1_addr  : m0_addr;
        win_wdata = win ? m1_wdata : m0_wdata;
    end

    always_ff @(posedge clk) begin
        if (!RSTN) begin
            state        <= IDLE;
            cnt          <= '0;
            last_gnt     <= 1'b1;
            gnt_id       <= 1'b0;
            m0_ack       <= 1'b0;
            m1_ack       <= 1'b0;
            m0_rdata     <= '0;
            m1_rdata     <= '0;
            addr_bus     <= '0;
            Cpu_data2bus <= '0;
            mem_w        <= 1'b0;
            busy         <= 1'b0;
            xfer_cnt     <= '0;
        end else begin
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            mem_w  <= 1'b0;
            case (state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        gnt_id       <= win;
                        addr_bus     <= win_addr;
                        Cpu_data2bus <= win_wdata;
                        mem_w        <= win_we;
                        cnt          <= WAIT_LD;
                        busy         <= 1'b1;
                        state        <= BUSY;
                    end
                end
                BUSY: begin
                    cnt <= cnt - 4'd1;
                    // Last wait cycle: the bus data is valid now.
                    if (cnt == 4'd1) begin
                        if (gnt_id) begin
                            m1_rdata <= Cpu_data4bus;
                            m1_ack   <= 1'b1;
                        end else begin
                            m0_rdata <= Cpu_data4bus;
                            m0_ack   <= 1'b1;
                        end
                        addr_bus     <= '0;
                        Cpu_data2bus <= '0;
                        last_gnt     <= gnt_id;
                        xfer_cnt     <= xfer_cnt + 16'd1;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
